// File: rtl/score_ctrl_pkg.sv
// score_ctrl_pkg: shared state encoding, winner codes and BCD limit for score_ctrl.
// Revision 1.0
`default_nettype none

package score_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_A    = 2'b01;
  localparam logic [1:0] W_B    = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  localparam logic [7:0] BCD_MAX = 8'h99;

endpackage

`default_nettype wire

// File: rtl/score_ctrl_bcd_inc2.sv
// bcd_inc2: combinational two-digit BCD +1, saturating at 99.
// Revision 1.0
`default_nettype none

module bcd_inc2
  import score_ctrl_pkg::*;
(
  input  logic [7:0] i_val,
  output logic [7:0] o_val
);

  always_comb begin
    o_val = i_val;
    if (i_val == BCD_MAX)
      o_val = BCD_MAX;
    else if (i_val[3:0] == 4'd9)
      o_val = {i_val[7:4] + 4'd1, 4'd0};
    else
      o_val = {i_val[7:4], i_val[3:0] + 4'd1};
  end

endmodule

`default_nettype wire

// File: rtl/score_ctrl.sv
// score_ctrl: two-player BCD score keeper with frame-aligned commits and digit-cell sequencer.
// Optional macro SCORE_BLINK_EN blinks the winner's digits in OVER.  Revision 1.0
`default_nettype none

module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int         H         = 32,
  parameter int         V         = 32,
  parameter int         X_A       = 64,
  parameter int         X_B       = 512,
  parameter int         Y0        = 16,
  parameter logic [7:0] WIN_SCORE = 8'h11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_a,
  input  logic       point_b,
  input  logic       new_game,
  input  logic       frame_start,
  input  logic [9:0] pixX,
  input  logic [9:0] pixY,
  output logic [7:0] score_a,
  output logic [7:0] score_b,
  output logic [3:0] digit_val,
  output logic [9:0] digit_posX,
  output logic [9:0] digit_posY,
  output logic       digit_en,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [9:0] c_XA_T = 10'(X_A);
  localparam logic [9:0] c_XA_O = 10'(X_A + H);
  localparam logic [9:0] c_XA_E = 10'(X_A + 2 * H);
  localparam logic [9:0] c_XB_T = 10'(X_B);
  localparam logic [9:0] c_XB_O = 10'(X_B + H);
  localparam logic [9:0] c_XB_E = 10'(X_B + 2 * H);
  localparam logic [9:0] c_Y_T  = 10'(Y0);
  localparam logic [9:0] c_Y_E  = 10'(Y0 + V);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_score_a, r_score_b, w_score_a_nxt, w_score_b_nxt;
  logic [1:0] r_pend_a, r_pend_b, w_pend_a_nxt, w_pend_b_nxt;
  logic [1:0] r_winner, w_winner_nxt;
  logic [7:0] w_inc_a, w_inc_b, w_post_a, w_post_b;
  logic [1:0] w_pend_a_sat, w_pend_b_sat;
  logic       w_commit_a, w_commit_b;

  bcd_inc2 u_inc_a (.i_val(r_score_a), .o_val(w_inc_a));
  bcd_inc2 u_inc_b (.i_val(r_score_b), .o_val(w_inc_b));

  // A point coinciding with frame_start joins the queue before the commit takes one out.
  assign w_pend_a_sat = (r_pend_a == 2'd3 || !point_a) ? r_pend_a : r_pend_a + 2'd1;
  assign w_pend_b_sat = (r_pend_b == 2'd3 || !point_b) ? r_pend_b : r_pend_b + 2'd1;
  assign w_commit_a   = frame_start && (w_pend_a_sat != 2'd0);
  assign w_commit_b   = frame_start && (w_pend_b_sat != 2'd0);
  assign w_post_a     = w_commit_a ? w_inc_a : r_score_a;
  assign w_post_b     = w_commit_b ? w_inc_b : r_score_b;

  always_comb begin
    w_state_nxt   = r_state;
    w_score_a_nxt = r_score_a;
    w_score_b_nxt = r_score_b;
    w_pend_a_nxt  = r_pend_a;
    w_pend_b_nxt  = r_pend_b;
    w_winner_nxt  = r_winner;
    if (new_game) begin
      w_state_nxt   = ST_PLAY;
      w_score_a_nxt = 8'h00;
      w_score_b_nxt = 8'h00;
      w_pend_a_nxt  = 2'd0;
      w_pend_b_nxt  = 2'd0;
      w_winner_nxt  = W_NONE;
    end else if (r_state == ST_PLAY) begin
      w_pend_a_nxt  = w_commit_a ? w_pend_a_sat - 2'd1 : w_pend_a_sat;
      w_pend_b_nxt  = w_commit_b ? w_pend_b_sat - 2'd1 : w_pend_b_sat;
      w_score_a_nxt = w_post_a;
      w_score_b_nxt = w_post_b;
      if (frame_start && (w_post_a == WIN_SCORE || w_post_b == WIN_SCORE)) begin
        w_state_nxt = ST_OVER;
        if (w_post_a == WIN_SCORE && w_post_b == WIN_SCORE)
          w_winner_nxt = W_DRAW;
        else if (w_post_a == WIN_SCORE)
          w_winner_nxt = W_A;
        else
          w_winner_nxt = W_B;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_score_a <= 8'h00;
      r_score_b <= 8'h00;
      r_pend_a  <= 2'd0;
      r_pend_b  <= 2'd0;
      r_winner  <= W_NONE;
    end else begin
      r_state   <= w_state_nxt;
      r_score_a <= w_score_a_nxt;
      r_score_b <= w_score_b_nxt;
      r_pend_a  <= w_pend_a_nxt;
      r_pend_b  <= w_pend_b_nxt;
      r_winner  <= w_winner_nxt;
    end
  end

`ifdef SCORE_BLINK_EN
  logic [5:0] r_frame_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_frame_cnt <= 6'd0;
    else if (new_game)
      r_frame_cnt <= 6'd0;
    else if (frame_start)
      r_frame_cnt <= r_frame_cnt + 6'd1;
  end
`endif

  logic       w_in_y, w_hit, w_tens, w_owner_a, w_en;
  logic [3:0] w_val;
  logic [9:0] w_posx;

  always_comb begin
    w_in_y    = (pixY >= c_Y_T) && (pixY < c_Y_E);
    w_hit     = 1'b0;
    w_tens    = 1'b0;
    w_owner_a = 1'b0;
    w_val     = 4'd0;
    w_posx    = 10'd0;
    if (w_in_y) begin
      if (pixX >= c_XA_T && pixX < c_XA_O) begin
        w_hit = 1'b1; w_tens = 1'b1; w_owner_a = 1'b1; w_val = r_score_a[7:4]; w_posx = c_XA_T;
      end else if (pixX >= c_XA_O && pixX < c_XA_E) begin
        w_hit = 1'b1; w_owner_a = 1'b1; w_val = r_score_a[3:0]; w_posx = c_XA_O;
      end else if (pixX >= c_XB_T && pixX < c_XB_O) begin
        w_hit = 1'b1; w_tens = 1'b1; w_val = r_score_b[7:4]; w_posx = c_XB_T;
      end else if (pixX >= c_XB_O && pixX < c_XB_E) begin
        w_hit = 1'b1; w_val = r_score_b[3:0]; w_posx = c_XB_O;
      end
    end
    w_en = w_hit && (r_state != ST_IDLE) && !(w_tens && w_val == 4'd0);
`ifdef SCORE_BLINK_EN
    if (r_state == ST_OVER && (w_owner_a ? r_winner[0] : r_winner[1]) && !r_frame_cnt[5])
      w_en = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_val  <= 4'd0;
      digit_posX <= 10'd0;
      digit_posY <= 10'd0;
      digit_en   <= 1'b0;
    end else begin
      digit_val  <= w_val;
      digit_posX <= w_posx;
      digit_posY <= w_hit ? c_Y_T : 10'd0;
      digit_en   <= w_en;
    end
  end

  assign score_a   = r_score_a;
  assign score_b   = r_score_b;
  assign winner    = r_winner;
  assign game_over = (r_state == ST_OVER);

endmodule

`default_nettype wire
